fnd_scan_ctrl: RTL and testbench

- Seven-segment (FND) multiplexed display scanner, directly downstream of the clock divider.
- Consumes the divider's CLK_1KHz output as a scan-rate strobe, sampled in the CLK_50MHz domain. No logic is clocked by CLK_1KHz itself.
- Each scan step drives one digit's common line and that digit's decoded hex segments. Frame-coherent data update prevents digit tearing.

---
 rtl/fnd_scan_if.sv | 13 +
 rtl/fnd_scan_ctrl.sv | 94 +++++++++
 tb/tb_fnd_scan_ctrl.sv | 114 +++++++++++
 3 files changed

// File: rtl/fnd_scan_if.sv
// fnd_scan_if: scan strobe, display data load and FND drive signals of the scanner.
interface fnd_scan_if #(parameter int NUM_DIGITS = 8);
  logic                    CLK_1KHz;
  logic                    ENABLE;
  logic [4*NUM_DIGITS-1:0] DATA;
  logic [NUM_DIGITS-1:0]   DP;
  logic                    DATA_LD;
  logic [7:0]              SEG;
  logic [NUM_DIGITS-1:0]   COM;
  logic                    FRAME_DONE;
  modport master (output CLK_1KHz, ENABLE, DATA, DP, DATA_LD, input SEG, COM, FRAME_DONE);
  modport slave  (input CLK_1KHz, ENABLE, DATA, DP, DATA_LD, output SEG, COM, FRAME_DONE);
endinterface

// File: rtl/fnd_scan_ctrl.sv
// fnd_scan_ctrl: multiplexed seven-segment scanner stepped by a synchronized 1 kHz strobe.
// Optional leading-zero blanking is built when FND_LEADING_ZERO_BLANK_EN is defined.
module fnd_scan_ctrl #(
  parameter int NUM_DIGITS     = 8,
  parameter bit COM_ACTIVE_LOW = 1'b1,
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input logic       CLK_50MHz,
  input logic       reset,
  fnd_scan_if.slave bus
);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int DW = 5 * NUM_DIGITS;
  localparam logic [15:0][6:0] HEX = {7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
                                      7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F};
  localparam logic [7:0] SEG_OFF = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [NUM_DIGITS-1:0] COM_OFF = COM_ACTIVE_LOW ? '1 : '0;
  logic                  sync1_q, sync2_q, hist_q;
  logic [IW-1:0]         idx_q, idx_d;
  logic                  valid_q, valid_d;
  logic [DW-1:0]         act_q, act_d, pend_q, pend_d;
  logic                  pflag_q, pflag_d;
  logic [7:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] com_q, com_d;
  logic                  fd_q, fd_d;
  logic                  tick, commit, on, blank;
  logic [DW-1:0]         bus_word;
  logic [3:0]            nib;
  logic [7:0]            lit;
  logic [NUM_DIGITS-1:0] onehot;
`ifdef FND_LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] blank_m;
  logic                  zrun;
  // a digit blanks only if it and every digit above it is an undotted zero
  always_comb begin
    blank_m = '0;
    zrun = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      zrun = zrun & (act_q[4*i +: 4] == 4'h0) & ~act_q[4*NUM_DIGITS + i];
      blank_m[i] = zrun;
    end
  end
  assign blank = blank_m[idx_q];
`else
  assign blank = 1'b0;
`endif
  always_comb begin
    tick = sync2_q & ~hist_q;
    commit = tick & (idx_q == IW'(NUM_DIGITS - 1));
    bus_word = {bus.DP, bus.DATA};
    idx_d = tick ? (commit ? '0 : idx_q + IW'(1)) : idx_q;
    valid_d = valid_q | tick;
    act_d = (commit & bus.DATA_LD) ? bus_word : (commit & pflag_q) ? pend_q : act_q;
    pend_d = bus.DATA_LD ? bus_word : pend_q;
    pflag_d = commit ? 1'b0 : (bus.DATA_LD | pflag_q);
    nib = act_q[4*idx_q +: 4];
    on = valid_q & bus.ENABLE;
    lit = (on & ~blank) ? {act_q[4*NUM_DIGITS + idx_q], HEX[nib]} : 8'h00;
    seg_d = SEG_ACTIVE_LOW ? ~lit : lit;
    onehot = on ? (NUM_DIGITS'(1) << idx_q) : '0;
    com_d = COM_ACTIVE_LOW ? ~onehot : onehot;
    fd_d = commit;
  end
  always_ff @(posedge CLK_50MHz) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      hist_q  <= 1'b0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      act_q   <= '0;
      pend_q  <= '0;
      pflag_q <= 1'b0;
      seg_q   <= SEG_OFF;
      com_q   <= COM_OFF;
      fd_q    <= 1'b0;
    end else begin
      sync1_q <= bus.CLK_1KHz;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      act_q   <= act_d;
      pend_q  <= pend_d;
      pflag_q <= pflag_d;
      seg_q   <= seg_d;
      com_q   <= com_d;
      fd_q    <= fd_d;
    end
  end
  assign bus.SEG = seg_q;
  assign bus.COM = com_q;
  assign bus.FRAME_DONE = fd_q;
endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// tb_fnd_scan_ctrl: randomized scan/load/enable stimulus against a digit-level display model.
module tb_fnd_scan_ctrl;
  localparam int N = 8;
  logic clk = 1'b0;
  logic rst;
  always #10 clk = ~clk;
  fnd_scan_if #(.NUM_DIGITS(N)) bus ();
  fnd_scan_ctrl #(.NUM_DIGITS(N)) dut (.CLK_50MHz(clk), .reset(rst), .bus(bus));
  int n_chk = 0, n_fail = 0, fd_cnt, hp;
  logic [6:0] hex_t [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  int          idx_m;
  bit          valid_m, pflag_m, h1, h2, h3;
  logic [31:0] act_data, pend_data;
  logic [7:0]  act_dp, pend_dp;
  logic [7:0]  e_seg, e_com;
  logic        e_fd;
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_edge();
    bit tick, on, blank, dpb;
    int nib;
    if (rst) begin
      e_seg = 8'h00; e_com = 8'hFF; e_fd = 1'b0;
      idx_m = 0; valid_m = 0; pflag_m = 0;
      act_data = 0; act_dp = 0; pend_data = 0; pend_dp = 0;
      h1 = 0; h2 = 0; h3 = 0;
    end else begin
      tick = h2 && !h3;
      on = valid_m && bus.ENABLE;
      nib = int'((act_data >> (4 * idx_m)) & 32'hF);
      dpb = act_dp[idx_m];
      blank = 1'b0;
`ifdef FND_LEADING_ZERO_BLANK_EN
      blank = idx_m > 0 && (act_data >> (4 * idx_m)) == 0 && (act_dp >> idx_m) == 0;
`endif
      e_seg = (on && !blank) ? {dpb, hex_t[nib]} : 8'h00;
      e_com = on ? ~(8'd1 << idx_m) : 8'hFF;
      e_fd = tick && idx_m == N - 1;
      if (tick) begin
        valid_m = 1;
        if (idx_m == N - 1) begin
          idx_m = 0;
          if (bus.DATA_LD) begin act_data = bus.DATA; act_dp = bus.DP; end
          else if (pflag_m) begin act_data = pend_data; act_dp = pend_dp; end
          pflag_m = 0;
        end else idx_m++;
      end
      if (bus.DATA_LD) begin
        pend_data = bus.DATA; pend_dp = bus.DP;
        if (!(tick && e_fd)) pflag_m = 1;
      end
      h3 = h2; h2 = h1; h1 = bus.CLK_1KHz;
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("seg", bus.SEG, e_seg);
    check("com", bus.COM, e_com);
    check("frame_done", bus.FRAME_DONE, e_fd);
    if (bus.FRAME_DONE) fd_cnt++;
  endtask
  initial begin
    rst = 1; bus.CLK_1KHz = 0; bus.ENABLE = 1; bus.DATA = 0; bus.DP = 0; bus.DATA_LD = 0;
    fd_cnt = 0;
    repeat (3) cyc();
    check("rst_seg", bus.SEG, 8'h00);
    check("rst_com", bus.COM, 8'hFF);
    check("rst_fd", bus.FRAME_DONE, 1'b0);
    rst = 0;
    repeat (5) cyc();
    check("idle_com", bus.COM, 8'hFF);
    bus.DATA = 32'h0123ABCD; bus.DP = 8'h01; bus.DATA_LD = 1;
    cyc();
    bus.DATA_LD = 0;
    for (int p = 0; p < 16; p++) begin
      for (int h = 0; h < 8; h++) begin
        bus.CLK_1KHz = (h < 4);
        cyc();
        if (fd_cnt >= 1 && bus.COM == 8'hFE) check("digit0", bus.SEG, 8'hDE);
`ifdef FND_LEADING_ZERO_BLANK_EN
        if (fd_cnt >= 1 && bus.COM == 8'h7F) check("digit7", bus.SEG, 8'h00);
`else
        if (fd_cnt >= 1 && bus.COM == 8'h7F) check("digit7", bus.SEG, 8'h3F);
`endif
      end
    end
    check("frames", fd_cnt, 2);
    hp = 3;
    for (int c = 0; c < 6000; c++) begin
      if (--hp == 0) begin
        bus.CLK_1KHz = ~bus.CLK_1KHz;
        hp = $urandom_range(1, 6);
      end
      bus.DATA_LD = ($urandom_range(0, 15) == 0);
      if (bus.DATA_LD) begin
        bus.DATA = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 4095));
        bus.DP = $urandom_range(0, 1) ? 8'($urandom) : 8'h00;
      end
      if ($urandom_range(0, 99) == 0) bus.ENABLE = ~bus.ENABLE;
      rst = ($urandom_range(0, 1499) == 0);
      cyc();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
